// File: rtl/serial_deserializer.sv
// serial_deserializer: assembles a strobed serial bit stream into
// parallel words, framed by sof, presented on a valid/ready port.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   din, din_en  : serial bit and its strobe
//   sof          : marks the strobed bit as bit 0 of a new word
//   dout         : assembled word (held in a separate output slot)
//   dout_valid   : dout holds an unconsumed word
//   dout_ready   : consumer accepts dout when dout_valid is high
//   busy         : a frame is partially received
//   bit_cnt      : bits received in the current frame
//   frame_err    : sticky, a frame was restarted before completion
//   overflow     : sticky, a completed word was dropped (slot full)
//   clr_err      : clears frame_err and overflow (set wins)
module serial_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din,
  input  logic                       din_en,
  input  logic                       sof,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       frame_err,
  output logic                       overflow,
  input  logic                       clr_err
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] sh_in, sh_new;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done, abort, ovf_set;

  // sh_in: shift register advanced by one bit.
  // sh_new: a fresh frame holding only its first bit.
  if (MSB_FIRST) begin : g_msb
    assign sh_in  = {sh_q[WIDTH-2:0], din};
    assign sh_new = {{(WIDTH-1){1'b0}}, din};
  end else begin : g_lsb
    assign sh_in  = {din, sh_q[WIDTH-1:1]};
    assign sh_new = {din, {(WIDTH-1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (din_en && sof) begin
          sh_d    = sh_new;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (din_en) begin
          if (sof) begin
            abort = 1'b1;
            sh_d  = sh_new;
            cnt_d = CW'(1);
          end else if (cnt_q == CW'(WIDTH-1)) begin
            // Word completes this edge; sh_in goes to the output slot.
            done    = 1'b1;
            sh_d    = sh_in;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            sh_d  = sh_in;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ovf_set = done & dout_valid & ~dout_ready;

  // Output slot: a word is dropped only if the slot stays full.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (done) begin
        if (!dout_valid || dout_ready) begin
          dout       <= sh_in;
          dout_valid <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
      frame_err <= abort | (frame_err & ~clr_err);
      overflow  <= ovf_set | (overflow & ~clr_err);
    end
  end

  assign busy    = (state_q == SHIFT);
  assign bit_cnt = cnt_q;

endmodule
